// File: rtl/reg8_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: FSM encoding, default
// sizes and pointer arithmetic reused by round-robin arbiters.
package reg8_write_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ID_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/reg8_write_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after i_ptr,
// wrapping to the lowest set request below i_ptr.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_found
);

  logic [ID_W-1:0] w_hi_idx;
  logic [ID_W-1:0] w_lo_idx;
  logic            w_hi_found;
  logic            w_lo_found;

  // Descending scan so the lowest qualifying index in each half wins.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (i_req[j]) begin
        if (j >= int'(i_ptr)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(j);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = ID_W'(j);
        end
      end else begin
        w_hi_found = w_hi_found;
      end
    end
    o_found = w_hi_found | w_lo_found;
    if (w_hi_found) begin
      o_idx = w_hi_idx;
    end else begin
      o_idx = w_lo_idx;
    end
  end

endmodule

// File: rtl/reg8_write_arbiter.sv
// Round-robin write arbiter for one shared enabled register: one-cycle write,
// readback check, then a one-cycle ack with error flag to the winner.
module reg8_write_arbiter
  import reg8_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ID_W    = DEF_ID_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0]         reg_q,
  output logic                      reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      wr_err,
  output logic                      busy,
  output logic [ID_W-1:0]           grant_id
);

  localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

  arb_state_e          r_state;
  arb_state_e          w_state_nxt;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant;
  logic [DATA_W-1:0]   r_data;
  logic                r_reg_en;
  logic                r_busy;
  logic [NUM_REQ-1:0]  r_ack;
  logic                r_wr_err;
  logic [ID_W-1:0]     w_win;
  logic                w_found;
  logic [DATA_W-1:0]   w_wdata_sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_win),
    .o_found (w_found)
  );

  // Write-data mux for the current round-robin winner.
  always_comb begin
    w_wdata_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == w_win) begin
        w_wdata_sel = wdata[i*DATA_W +: DATA_W];
      end else begin
        w_wdata_sel = w_wdata_sel;
      end
    end
  end

  // Next-state: arbitration only in IDLE, then one cycle per phase.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt = ST_WRITE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WRITE: w_state_nxt = ST_CHECK;
      ST_CHECK: w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs are registered from the next state so nothing from req/wdata/reg_q
  // reaches a port combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_data   <= '0;
      r_reg_en <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= '0;
      r_wr_err <= 1'b0;
    end else begin
      r_reg_en <= (w_state_nxt == ST_WRITE);
      r_busy   <= (w_state_nxt != ST_IDLE);
      if ((r_state == ST_IDLE) && w_found) begin
        r_grant <= w_win;
        r_data  <= w_wdata_sel;
      end
      // reg_q is valid in CHECK: the register captured r_data at the end of WRITE.
      if (r_state == ST_CHECK) begin
        r_ack    <= ONE_HOT_0 << r_grant;
        r_wr_err <= (reg_q != r_data);
      end else begin
        r_ack    <= '0;
        r_wr_err <= 1'b0;
      end
      if (r_state == ST_DONE) begin
        r_rr_ptr <= ID_W'(next_idx(int'(r_grant), NUM_REQ));
      end
    end
  end

  assign reg_en   = r_reg_en;
  assign reg_d    = r_data;
  assign ack      = r_ack;
  assign wr_err   = r_wr_err;
  assign busy     = r_busy;
  assign grant_id = r_grant;

endmodule

// File: doc/reg8_write_arbiter.md
Name: reg8_write_arbiter

Overview:
- Shares one 8-bit enabled register (clk/reset/enable/d/q datapath) between NUM_REQ requesters.
- Picks one pending requester by round-robin and drives the register's enable and d for exactly one cycle.
- Reads q back to verify the write, then returns a one-cycle ack (plus error flag) to the winner.
- Sits between requesting blocks and the register instance; it is the only driver of the register's enable/d.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width; must match the register width.
- ID_W, 2, grant index width; equals ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 resets immediately; release is synchronous to clk).
- req  input  NUM_REQ  per-requester write request; level, held until ack.
- wdata  input  NUM_REQ*DATA_W  packed write data; requester i uses bits [i*DATA_W +: DATA_W].
- reg_q  input  DATA_W  readback from the shared register q.
- reg_en  output  1  enable to the shared register.
- reg_d  output  DATA_W  data to the shared register.
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- wr_err  output  1  high with ack when readback mismatched; otherwise 0.
- busy  output  1  high in any state other than IDLE.
- grant_id  output  ID_W  index of the current or most recent winner.

Behaviour:
- All outputs are registered or decoded from registered state only; there are no combinational paths from req/wdata/reg_q to outputs.
- Reset values: state=IDLE, rr_ptr=0, reg_en=0, reg_d=0, ack=0, wr_err=0, busy=0, grant_id=0, latched data=0.
- FSM, one state per cycle:
  - IDLE: if any req bit is set, select winner w = first set bit searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. Latch w into grant_id and wdata[w] into the data latch, then go to WRITE. If no req is set, stay in IDLE.
  - WRITE: reg_en=1, reg_d=latched data, for exactly this one cycle. The register captures the data at the end of this cycle. Go to CHECK.
  - CHECK: reg_en=0. Compare reg_q against latched data and register the result. Go to DONE.
  - DONE: ack[grant_id]=1 for exactly one cycle. wr_err = registered mismatch. rr_ptr = (grant_id+1) mod NUM_REQ. Go to IDLE.
- Latency: req sampled in IDLE at edge N -> reg_en high in cycle N+1 -> ack in cycle N+3.
- Throughput: at most one write per 4 cycles. IDLE always lasts at least one cycle between transactions.
- reg_d holds its last value when reg_en=0; it returns to 0 only on reset.
- Fairness: a continuously asserted req is granted within NUM_REQ transactions.
- If req[w] drops after grant, the transaction still completes and ack[w] still pulses. Requesters that do not want the ack ignore it.
- A new req asserted while busy waits. Arbitration happens only in IDLE.
- An all-requesters-asserted tie is resolved purely by rr_ptr.
- If the register's own reset clears q between WRITE and CHECK, the mismatch is reported: wr_err=1 with ack.
- Reset asserted mid-transaction: immediate return to IDLE, no ack issued, rr_ptr=0. The register may already hold the write.
- req bits at or above NUM_REQ do not exist; wdata slices are independent of req.

Decomposition:
- Shared header reg_arb_defs.vh holds:
  - state encodings IDLE=2'd0, WRITE=2'd1, CHECK=2'd2, DONE=2'd3;
  - the default DATA_W=8.
- Sub-module rr_pick: purely combinational round-robin selector. Inputs are req and rr_ptr; outputs are winner index and a "found" flag. It is reused by future shared-resource arbiters.
- The FSM, data latch and compare stay in reg8_write_arbiter.

Test Plan:
- Reset: hold reset=0 with req=4'b1111 -> all outputs 0, busy=0. Release reset -> the first grant goes to requester 0.
- Single write: req=4'b0100, wdata[2]=8'hAA -> reg_en=1, reg_d=8'hAA exactly one cycle after sampling. ack=4'b0100 two cycles later, wr_err=0, grant_id=2.
- Round-robin: req=4'b1111 held, distinct data 8'h11/8'h22/8'h33/8'h44 -> grants in order 0,1,2,3,0. Each ack is 4 cycles apart and reg_d matches each source.
- Readback error: stub reg_q forced to 8'h00 while writing 8'h0F -> ack pulses with wr_err=1. Next transaction with a correct readback gives wr_err=0.
- Early drop: req[1] high for one cycle only, wdata[1]=8'hCC -> the write of 8'hCC still occurs and ack[1] still pulses. No second grant to requester 1.
- Reset mid-op: assert reset during CHECK -> no ack, busy=0 immediately. After release, req=4'b1000 yields grant_id=3 (rr_ptr restarted at 0).
